ps2_scancode_rx: RTL and testbench



---
 rtl/ps2_scancode_rx_pkg.sv | 20 ++
 rtl/ps2_sync_edge.sv | 69 ++++++
 rtl/ps2_scancode_rx.sv | 130 +++++++++++++
 tb/tb_ps2_scancode_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_rx_pkg.sv
// rtl/ps2_scancode_rx_pkg.sv - shared prefixes, frame length, FSM states and parity helper for the PS/2 receiver
package ps2_scancode_rx_pkg;

  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam int         PS2_FRAME_LEN    = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - pin synchronisers and PS2_CLK falling-edge detector
// Optional PS2_CLK glitch filter enabled by PS2_GLITCH_FILTER_EN.
module ps2_sync_edge
`ifdef PS2_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 8
)
`endif
(
  input  logic Clock,
  input  logic Reset,
  input  logic iPS2Clk,
  input  logic iPS2Data,
  output logic wFall,
  output logic wDataSync
);

  logic [1:0] clkSync;
  logic [1:0] dataSync;
  logic       clkLevel;
  logic       clkPrev;

  // Synchronisers reset to 1 so an idle bus never produces a spurious edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], iPS2Clk};
      dataSync <= {dataSync[0], iPS2Data};
    end
  end

  assign wDataSync = dataSync[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] stableCnt;
  logic          clkFilt;

  // Level follows the synchronised clock only after FILTER_LEN differing samples in a row.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clkFilt   <= 1'b1;
      stableCnt <= '0;
    end else if (clkSync[1] == clkFilt) begin
      stableCnt <= '0;
    end else if (stableCnt == FW'(FILTER_LEN - 1)) begin
      clkFilt   <= clkSync[1];
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + 1'b1;
    end
  end

  assign clkLevel = clkFilt;
`else
  assign clkLevel = clkSync[1];
`endif

  always_ff @(posedge Clock) begin
    if (Reset) clkPrev <= 1'b1;
    else       clkPrev <= clkLevel;
  end

  assign wFall = clkPrev & ~clkLevel;

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - single-clock PS/2 keyboard scancode receiver with prefix decoding
// Optional PS2_CLK glitch filter enabled by PS2_GLITCH_FILTER_EN.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN = 8
`endif
)
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  output logic [7:0] oScanCode,
  output logic       oKeyRelease,
  output logic       oExtended,
  output logic       oValid,
  output logic       oFrameError
);

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = PS2_FRAME_LEN - 3;

  ps2State_t     state;
  ps2State_t     stateNext;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [TW-1:0] timeoutCnt;
  logic          relPrefix;
  logic          extPrefix;
  logic          wFall;
  logic          wDataSync;
  logic          timeoutHit;

`ifdef PS2_GLITCH_FILTER_EN
  ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) uSyncEdge (
`else
  ps2_sync_edge uSyncEdge (
`endif
    .Clock     (Clock),
    .Reset     (Reset),
    .iPS2Clk   (iPS2Clk),
    .iPS2Data  (iPS2Data),
    .wFall     (wFall),
    .wDataSync (wDataSync)
  );

  // An edge in the same cycle as the limit wins: the line is still alive.
  always_comb begin
    stateNext  = state;
    timeoutHit = 1'b0;
    if (state != IDLE && !wFall && timeoutCnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timeoutHit = 1'b1;
      stateNext  = IDLE;
    end else if (wFall) begin
      case (state)
        IDLE:    if (!wDataSync) stateNext = DATA;
        DATA:    if (bitCnt == 3'(DATA_BITS - 1)) stateNext = PARITY;
        PARITY:  stateNext = STOP;
        STOP:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bitCnt      <= '0;
      shiftReg    <= '0;
      parityBit   <= 1'b0;
      timeoutCnt  <= '0;
      relPrefix   <= 1'b0;
      extPrefix   <= 1'b0;
      oScanCode   <= '0;
      oKeyRelease <= 1'b0;
      oExtended   <= 1'b0;
      oValid      <= 1'b0;
      oFrameError <= 1'b0;
    end else begin
      oValid      <= 1'b0;
      oFrameError <= 1'b0;

      if (stateNext == IDLE || wFall) timeoutCnt <= '0;
      else                            timeoutCnt <= timeoutCnt + 1'b1;

      // Timeout abandons the frame but keeps any prefix already collected.
      if (timeoutHit) begin
        oFrameError <= 1'b1;
      end else if (wFall) begin
        case (state)
          IDLE: bitCnt <= '0;
          DATA: begin
            shiftReg <= {wDataSync, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
          end
          PARITY: parityBit <= wDataSync;
          STOP: begin
            if (!oddParityOk(shiftReg, parityBit) || !wDataSync) begin
              oFrameError <= 1'b1;
              relPrefix   <= 1'b0;
              extPrefix   <= 1'b0;
            end else if (shiftReg == PS2_BREAK_PREFIX) begin
              relPrefix <= 1'b1;
            end else if (shiftReg == PS2_EXT_PREFIX) begin
              extPrefix <= 1'b1;
            end else begin
              oScanCode   <= shiftReg;
              oKeyRelease <= relPrefix;
              oExtended   <= extPrefix;
              oValid      <= 1'b1;
              relPrefix   <= 1'b0;
              extPrefix   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - self-checking bench for ps2_scancode_rx against a frame-level reference model
module tb_ps2_scancode_rx;
  import ps2_scancode_rx_pkg::*;

  localparam int TO = 300;
  localparam int HP = 25;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = 3 + 8;
`else
  localparam int LAT = 3;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] oScanCode;
  logic       oKeyRelease;
  logic       oExtended;
  logic       oValid;
  logic       oFrameError;

  always #5 Clock = ~Clock;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPS2Clk     (ps2Clk),
    .iPS2Data    (ps2Data),
    .oScanCode   (oScanCode),
    .oKeyRelease (oKeyRelease),
    .oExtended   (oExtended),
    .oValid      (oValid),
    .oFrameError (oFrameError)
  );

  int checks = 0;
  int failures = 0;

  logic [9:0] vq[$];
  int errTotal = 0;
  int bothCnt = 0;

  always @(negedge Clock) begin
    if (oValid) vq.push_back({oKeyRelease, oExtended, oScanCode});
    if (oFrameError) errTotal++;
    if (oValid && oFrameError) bothCnt++;
  end

  logic [9:0] expQ[$];
  int expErr = 0;
  logic mRel = 1'b0;
  logic mExt = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic badPar, input logic stopB);
    return {stopB, (~^d) ^ badPar, d, 1'b0};
  endfunction

  task automatic ps2Bit(input logic b);
    ps2Data = b;
    repeat (HP) @(posedge Clock);
    #1 ps2Clk = 1'b0;
    repeat (HP) @(posedge Clock);
    #1 ps2Clk = 1'b1;
  endtask

  task automatic sendRange(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2Bit(f[i]);
    ps2Data = 1'b1;
  endtask

  // Reference behaviour for one complete frame, at byte level.
  task automatic modelFrame(input logic [7:0] d, input logic good);
    if (!good) begin
      expErr++;
      mRel = 1'b0;
      mExt = 1'b0;
    end else if (d == 8'hF0) begin
      mRel = 1'b1;
    end else if (d == 8'hE0) begin
      mExt = 1'b1;
    end else begin
      expQ.push_back({mRel, mExt, d});
      mRel = 1'b0;
      mExt = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic badPar, input logic stopB);
    sendRange(mkFrame(d, badPar, stopB), 0, PS2_FRAME_LEN - 1);
    modelFrame(d, !badPar && stopB);
  endtask

  task automatic verify(input string tag);
    repeat (5) @(posedge Clock);
    #1;
    check({tag, "_errors"}, errTotal, expErr);
    check({tag, "_valid_count"}, vq.size(), expQ.size());
    while (vq.size() > 0 && expQ.size() > 0)
      check({tag, "_code"}, {22'd0, vq.pop_front()}, {22'd0, expQ.pop_front()});
    vq.delete();
    expQ.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] f;
    int k;
    logic [7:0] d;
    int r;

    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", {oScanCode, oKeyRelease, oExtended, oValid, oFrameError}, 32'd0);
    Reset = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    check("idle_outputs", {oScanCode, oKeyRelease, oExtended, oValid, oFrameError}, 32'd0);

    frame(8'h1C, 1'b0, 1'b1);
    verify("make_1c");
    check("held_code", oScanCode, 8'h1C);

    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    verify("break_1c");

    frame(8'hE0, 1'b0, 1'b1);
    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h75, 1'b0, 1'b1);
    verify("ext_break_75");

    frame(8'h1C, 1'b1, 1'b1);
    frame(8'h32, 1'b0, 1'b1);
    verify("parity_err");

    frame(8'hE0, 1'b0, 1'b1);
    frame(8'h3A, 1'b0, 1'b0);
    frame(8'h29, 1'b0, 1'b1);
    verify("stop_err");

    // Partial frame after a break prefix: timeout must keep the prefix.
    frame(8'hF0, 1'b0, 1'b1);
    f = mkFrame(8'h5A, 1'b0, 1'b1);
    sendRange(f, 0, 4);
    ps2Data = f[5];
    repeat (HP) @(posedge Clock);
    #1 ps2Clk = 1'b0;
    k = 0;
    while (k < TO + LAT + 20) begin
      @(posedge Clock);
      #1;
      k++;
      if (oFrameError) break;
    end
    check("timeout_latency", k, TO + LAT);
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    expErr++;
    repeat (HP) @(posedge Clock);
    frame(8'h1C, 1'b0, 1'b1);
    verify("after_timeout");

    // Reset mid-frame: remaining bits of 0xF3 are all ones, so they look idle.
    frame(8'hE0, 1'b0, 1'b1);
    f = mkFrame(8'hF3, 1'b0, 1'b1);
    sendRange(f, 0, 4);
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    check("midframe_reset_outputs", {oScanCode, oKeyRelease, oExtended, oValid, oFrameError}, 32'd0);
    mRel = 1'b0;
    mExt = 1'b0;
    sendRange(f, 5, PS2_FRAME_LEN - 1);
    repeat (HP) @(posedge Clock);
    frame(8'h1C, 1'b0, 1'b1);
    verify("after_reset");

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 5);
      d = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      r = $urandom_range(0, 9);
      frame(d, r == 0, r != 1);
      verify($sformatf("random_%0d", n));
    end

    check("valid_and_error_overlap", bothCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
